// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, state encoding and alignment helper for the MEM stage
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } mem_state_t;

    // Size code 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Little-endian lane mapping; misaligned halves never reach here because the stage filters them
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        be      = 4'b1111;
        wdata   = wd;
        ld_data = shifted;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{wd[7:0]}};
                ld_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{wd[15:0]}};
                ld_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage driving a req/ack data memory with stall and error reporting
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        in_RegWrite,
    input  logic        in_MemtoReg,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [1:0]  in_MemSize,
    input  logic        in_MemSigned,
    input  logic [31:0] in_ALUOut,
    input  logic [31:0] in_WriteData,
    input  logic [4:0]  in_WriteReg,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [31:0] ALUOut,
    output logic [31:0] ReadData,
    output logic [4:0]  WriteReg,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    mem_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [29:0]      addr_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [1:0]       size_q;
    logic [1:0]       lo_q;
    logic             sgn_q;
    logic             abort_q;
    logic [31:0]      rdata_q;

    logic             mem_op;
    logic             misal;
    logic             busy;
    logic             timeout_hit;
    logic [1:0]       al_size;
    logic [1:0]       al_lo;
    logic             al_sgn;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_ld;

    assign mem_op      = in_MemRead | in_MemWrite;
    assign misal       = mem_op & is_misaligned(in_MemSize, in_ALUOut[1:0]);
    assign busy        = (state == S_BUSY);
    // An ack arriving in the final allowed cycle takes priority over the abort
    assign timeout_hit = busy & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));

    // In IDLE the aligner sees the incoming instruction (store lanes); in BUSY the latched load shape
    assign al_size = busy ? size_q : in_MemSize;
    assign al_lo   = busy ? lo_q   : in_ALUOut[1:0];
    assign al_sgn  = busy ? sgn_q  : in_MemSigned;

    mem_lane_align u_align (
        .size      (al_size),
        .is_signed (al_sgn),
        .addr_lo   (al_lo),
        .wd        (in_WriteData),
        .rdata     (dmem_rdata),
        .be        (al_be),
        .wdata     (al_wdata),
        .ld_data   (al_ld)
    );

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state and per-cycle control; stall/error outputs are held low while reset is asserted
    always_comb begin
        state_nx = state;
        Stall    = 1'b0;
        AddrErr  = 1'b0;
        BusErr   = 1'b0;
        RegWrite = in_RegWrite;
        case (state)
            S_IDLE: begin
                if (misal) begin
                    AddrErr  = 1'b1;
                    RegWrite = 1'b0;
                end else if (mem_op) begin
                    Stall    = 1'b1;
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                Stall  = 1'b1;
                BusErr = timeout_hit;
                if (dmem_ack || timeout_hit) state_nx = S_DONE;
            end
            S_DONE: begin
                RegWrite = in_RegWrite & ~abort_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (!RSTn) begin
            Stall   = 1'b0;
            AddrErr = 1'b0;
        end
    end

    // Access latch, wait counter and load-result capture
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            abort_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (mem_op && !misal) begin
                        addr_q  <= in_ALUOut[31:2];
                        we_q    <= in_MemWrite;
                        be_q    <= al_be;
                        wdata_q <= al_wdata;
                        size_q  <= in_MemSize;
                        lo_q    <= in_ALUOut[1:0];
                        sgn_q   <= in_MemSigned;
                        abort_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dmem_ack) begin
                        if (!we_q) rdata_q <= al_ld;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        abort_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req   = busy;
    assign dmem_we    = busy & we_q;
    assign dmem_be    = busy ? be_q : 4'b0000;
    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_wdata = wdata_q;

    assign MemtoReg = in_MemtoReg;
    assign ALUOut   = in_ALUOut;
    assign WriteReg = in_WriteReg;
    assign ReadData = rdata_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (MEM) stage of the 5-stage pipelined CPU. Sits between the EX/MEM pipeline register and the MEM/WB register; its outputs connect directly to the MEM/WB inputs.
- Runs loads and stores against a data memory through a req/ack handshake that may wait any number of cycles.
- Handles byte/halfword/word lane steering and load extension, and stalls the pipeline while an access is outstanding.
- Flags misaligned addresses and bus timeouts.

Parameters:
- TIMEOUT, 16, maximum number of cycles in BUSY without dmem_ack before the access is aborted.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- in_RegWrite  in  1  from EX/MEM.
- in_MemtoReg  in  1  from EX/MEM.
- in_MemRead  in  1  load enable.
- in_MemWrite  in  1  store enable.
- in_MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- in_MemSigned  in  1  sign-extend load data when 1.
- in_ALUOut  in  32  effective address, or ALU result for non-memory instructions.
- in_WriteData  in  32  store data (rt).
- in_WriteReg  in  5  destination register.
- RegWrite  out  1  to MEM/WB.
- MemtoReg  out  1  to MEM/WB.
- ALUOut  out  32  to MEM/WB.
- ReadData  out  32  to MEM/WB, extended load data.
- WriteReg  out  5  to MEM/WB.
- Stall  out  1  to hazard unit; freezes PC, IF/ID, ID/EX and EX/MEM, and holds MEM/WB.
- AddrErr  out  1  misaligned-access pulse.
- BusErr  out  1  timeout pulse.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address ({in_ALUOut[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete.
- dmem_rdata  in  32  read word, valid with ack.

Behaviour:
- Single clock CLK; RSTn is asynchronous, active-low.

Reset (RSTn low):
- state=IDLE, counter=0, rdata_q=0.
- dmem_req=0, dmem_we=0, dmem_be=0.
- Stall=0, AddrErr=0, BusErr=0.
- ReadData=0.

Access classification:
- mem = in_MemRead|in_MemWrite.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.

States:
- IDLE
  - mem and aligned: Stall=1 combinationally; next state BUSY; latch address, we, be and wdata.
  - Misaligned: AddrErr=1 for this cycle only; no memory access; RegWrite forced 0; Stall=0.
  - Non-memory instruction: Stall=0; control and ALUOut pass through combinationally.
- BUSY
  - dmem_req=1 with addr, we, be and wdata held stable; Stall=1; counter increments each cycle.
  - dmem_ack: capture extended dmem_rdata into rdata_q (loads only); deassert dmem_req next edge; go to DONE.
  - counter reaches TIMEOUT with no ack: BusErr pulses 1 cycle; rdata_q=0; go to DONE with an abort flag that forces RegWrite to 0.
  - ack in the same cycle as timeout: ack wins, no BusErr.
- DONE
  - Stall=0; ReadData=rdata_q; abort flag applied.
  - Next state IDLE. EX/MEM advances at this edge, so back-to-back accesses restart cleanly.

Timing and handshake:
- Latency with a zero-wait ack: 2 stall cycles per load or store.
- Non-memory instructions add no latency.
- dmem_ack outside BUSY is ignored.
- dmem_ack after a timeout abort is ignored.

Lane and extension rules (little-endian):
- Byte: be = 1<<addr[1:0]; wdata = {4{wd[7:0]}}.
- Half: be = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
- Word: be = 1111; wdata = wd.
- Load: select lane by addr[1:0]; sign- or zero-extend per in_MemSigned.

Other rules:
- Stores pass in_RegWrite through unchanged; it is 0 from decode.
- Reset asserted mid-access: return to IDLE immediately and drop dmem_req; memory-side completion is discarded.

Decomposition:
- Shared package mem_pkg:
  - MemSize codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encoding S_IDLE, S_BUSY, S_DONE.
- Natural sub-module: mem_lane_align, a combinational block that produces be, wdata and extended load data from size, signed flag, addr[1:0] and raw data. It is reused for unit testing.

Test Plan:
- Word load at 0x100, rdata 0xDEADBEEF, ack in the first BUSY cycle -> Stall high 2 cycles, dmem_be=1111, ReadData=0xDEADBEEF in DONE.
- Signed byte load at 0x103, rdata 0x80112233 -> dmem_be=1000, ReadData=0xFFFFFF80. Unsigned -> 0x00000080.
- Half store at 0x202, data 0x0000ABCD, ack after 3 wait cycles -> dmem_be=1100, dmem_wdata=0xABCDABCD, req stable 4 cycles, Stall high 5 cycles.
- Word load at 0x101 -> AddrErr pulse, dmem_req never asserted, RegWrite=0, Stall=0.
- No ack for TIMEOUT=16 cycles -> BusErr pulse on cycle 16 of BUSY, RegWrite=0, ReadData=0. A later stray ack is ignored.
- RSTn low during BUSY -> dmem_req=0 and Stall=0 immediately; after release the next add instruction passes ALUOut with zero stall.
